// File: rtl/writeback_queue.sv
// Register-file writeback queue: merges ALU and load writebacks into an in-order FIFO,
// retires one entry per cycle and flags read-after-write hazards against queued entries.
module writeback_queue #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REG   = 32,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alu_valid,
    input  logic [$clog2(NUM_REG)-1:0]   alu_rd,
    input  logic [WORD_SIZE-1:0]         alu_data,
    output logic                         alu_ready,
    input  logic                         mem_valid,
    input  logic [$clog2(NUM_REG)-1:0]   mem_rd,
    input  logic [WORD_SIZE-1:0]         mem_data,
    output logic                         mem_ready,
    output logic [$clog2(NUM_REG)-1:0]   rf_A3,
    output logic [WORD_SIZE-1:0]         rf_WD3,
    output logic                         rf_we,
    input  logic [$clog2(NUM_REG)-1:0]   q_A1,
    input  logic [$clog2(NUM_REG)-1:0]   q_A2,
    output logic                         hazard1,
    output logic                         hazard2,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int RW = $clog2(NUM_REG);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [RW-1:0]        rd_q   [DEPTH];
    logic [WORD_SIZE-1:0] data_q [DEPTH];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [PW-1:0]        alu_slot;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        free;
    logic [CW-1:0]        alu_need;
    logic                 mem_nz;
    logic                 alu_nz;
    logic                 mem_push;
    logic                 alu_push;
    logic                 pop;
    logic [PW-1:0]        off;
    logic                 hit1;
    logic                 hit2;

    assign count = cnt;
    assign free  = CW'(DEPTH) - cnt;
    assign pop   = (cnt != '0);

    assign mem_nz = (mem_rd != '0);
    assign alu_nz = (alu_rd != '0);

    // A pending nonzero load reserves one slot ahead of the ALU request.
    assign alu_need  = CW'(1) + CW'(mem_valid && mem_nz);
    assign mem_ready = !reset && (!mem_nz || (free >= CW'(1)));
    assign alu_ready = !reset && (!alu_nz || (free >= alu_need));

    // rd==0 requests complete the handshake but are dropped here.
    assign mem_push = mem_valid && mem_ready && mem_nz;
    assign alu_push = alu_valid && alu_ready && alu_nz;
    assign alu_slot = tail + PW'(mem_push);

    assign rf_we  = !reset && pop;
    assign rf_A3  = rd_q[head];
    assign rf_WD3 = data_q[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (pop) begin
                head <= head + PW'(1);
            end
            tail <= tail + PW'(mem_push) + PW'(alu_push);
            cnt  <= cnt + CW'(mem_push) + CW'(alu_push) - CW'(pop);
        end
    end

    // Load goes in first so it is older than a same-cycle ALU entry.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            rd_q[tail]   <= mem_rd;
            data_q[tail] <= mem_data;
        end
        if (alu_push) begin
            rd_q[alu_slot]   <= alu_rd;
            data_q[alu_slot] <= alu_data;
        end
    end

    // An entry is occupied when its distance from head is below the count.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head;
            if ({1'b0, off} < cnt) begin
                if (rd_q[i] == q_A1) hit1 = 1'b1;
                if (rd_q[i] == q_A2) hit2 = 1'b1;
            end
        end
    end

    assign hazard1 = !reset && (q_A1 != '0) && hit1;
    assign hazard2 = !reset && (q_A2 != '0) && hit2;

endmodule
